// File: rtl/vec_pkg.sv
// Shared encodings for the strided vector load/store unit.
// Contents: FSM states, SEW codes and the base byte-strobe patterns.
package vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SEW_8   = 2'b00;
  localparam logic [1:0] SEW_16  = 2'b01;
  localparam logic [1:0] SEW_32  = 2'b10;
  localparam logic [1:0] SEW_BAD = 2'b11;

  localparam logic [3:0] STRB_8  = 4'b0001;
  localparam logic [3:0] STRB_16 = 4'b0011;
  localparam logic [3:0] STRB_32 = 4'b1111;

  function automatic logic [31:0] sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_8:   sew_mask = 32'h0000_00ff;
      SEW_16:  sew_mask = 32'h0000_ffff;
      SEW_32:  sew_mask = 32'hffff_ffff;
      default: sew_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/vec_lane_align.sv
// Byte-lane placement for one vector element within a 32-bit memory word:
// alignment check, store data/strobe shifting and load extraction.
module vec_lane_align
  import vec_pkg::*;
(
  input  logic [1:0]  sew,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic        aligned,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_elem
);

  logic [31:0] mask;
  logic [3:0]  strb_base;
  logic [4:0]  shamt;

  always_comb begin
    aligned   = 1'b1;
    strb_base = STRB_8;
    case (sew)
      SEW_16: begin
        aligned   = ~addr_lo[0];
        strb_base = STRB_16;
      end
      SEW_32: begin
        aligned   = (addr_lo == 2'b00);
        strb_base = STRB_32;
      end
      SEW_BAD: begin
        aligned   = 1'b0;
        strb_base = 4'b0000;
      end
      default: begin
        aligned   = 1'b1;
        strb_base = STRB_8;
      end
    endcase
  end

  assign mask    = sew_mask(sew);
  assign shamt   = {addr_lo, 3'b000};
  assign wdata   = (st_data & mask) << shamt;
  assign wstrb   = strb_base << addr_lo;
  assign ld_elem = (ld_word >> shamt) & mask;

endmodule

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store sequencer: walks vl elements at base + i*stride,
// one memory transaction per aligned element, misaligned ones flagged and skipped.
module vec_strided_lsu
  import vec_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_store,
  input  logic [31:0]      cmd_base,
  input  logic [31:0]      cmd_stride,
  input  logic [IDX_W-1:0] cmd_vl,
  input  logic [1:0]       cmd_sew,
  output logic             elem_wr_valid,
  output logic [IDX_W-1:0] elem_wr_idx,
  output logic [31:0]      elem_wr_data,
  output logic [IDX_W-1:0] elem_rd_idx,
  input  logic [31:0]      elem_rd_data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  output logic             done,
  output logic             err
);

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  lsu_state_t        state;
  logic [IDX_W-1:0]  i_r;
  logic [IDX_W-1:0]  vl_r;
  logic [31:0]       addr_r;
  logic signed [31:0] stride_r;
  logic [1:0]        sew_r;
  logic              store_r;
  logic              err_sticky;

  logic [31:0]       addr_next;
  logic              lane_aligned;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_wstrb;
  logic [31:0]       lane_ld;

  // Running address is unchanged while in WAIT, so it also selects the load lanes.
  vec_lane_align u_lane (
    .sew     (sew_r),
    .addr_lo (addr_r[1:0]),
    .st_data (elem_rd_data),
    .ld_word (mem_rdata),
    .aligned (lane_aligned),
    .wdata   (lane_wdata),
    .wstrb   (lane_wstrb),
    .ld_elem (lane_ld)
  );

  assign addr_next   = addr_r + $unsigned(stride_r);
  assign cmd_ready   = (state == ST_IDLE);
  assign elem_rd_idx = i_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      i_r           <= '0;
      vl_r          <= '0;
      addr_r        <= '0;
      stride_r      <= '0;
      sew_r         <= SEW_8;
      store_r       <= 1'b0;
      err_sticky    <= 1'b0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      elem_wr_valid <= 1'b0;
      elem_wr_idx   <= '0;
      elem_wr_data  <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      elem_wr_valid <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            store_r    <= cmd_store;
            sew_r      <= cmd_sew;
            vl_r       <= cmd_vl;
            stride_r   <= cmd_stride;
            addr_r     <= cmd_base;
            i_r        <= '0;
            err_sticky <= 1'b0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sew_r == SEW_BAD) begin
            err_sticky <= 1'b1;
            state      <= ST_DONE;
          end else if (i_r == vl_r) begin
            state <= ST_DONE;
          end else if (lane_aligned) begin
            mem_valid <= 1'b1;
            mem_addr  <= addr_r;
            mem_wstrb <= store_r ? lane_wstrb : 4'b0000;
            mem_wdata <= store_r ? lane_wdata : 32'h0;
            state     <= ST_WAIT;
          end else begin
            // Misaligned element: flag it and move on without touching memory.
            err_sticky <= 1'b1;
            i_r        <= i_r + IDX_ONE;
            addr_r     <= addr_next;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            i_r       <= i_r + IDX_ONE;
            addr_r    <= addr_next;
            if (!store_r) begin
              elem_wr_valid <= 1'b1;
              elem_wr_idx   <= i_r;
              elem_wr_data  <= lane_ld;
            end
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          err   <= err_sticky;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Directed bench for vec_strided_lsu: table of strided commands with
// hand-computed transactions and register-file writes, plus a reset-in-WAIT sequence.
module tb_vec_strided_lsu;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_store;
  logic [31:0] cmd_base;
  logic [31:0] cmd_stride;
  logic [7:0]  cmd_vl;
  logic [1:0]  cmd_sew;
  logic        elem_wr_valid;
  logic [7:0]  elem_wr_idx;
  logic [31:0] elem_wr_data;
  logic [7:0]  elem_rd_idx;
  logic [31:0] elem_rd_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;

  vec_strided_lsu #(.IDX_W(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_store     (cmd_store),
    .cmd_base      (cmd_base),
    .cmd_stride    (cmd_stride),
    .cmd_vl        (cmd_vl),
    .cmd_sew       (cmd_sew),
    .elem_wr_valid (elem_wr_valid),
    .elem_wr_idx   (elem_wr_idx),
    .elem_wr_data  (elem_wr_data),
    .elem_rd_idx   (elem_rd_idx),
    .elem_rd_data  (elem_rd_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory words and store-source register file
  logic [31:0] mem_words [1024];
  logic [31:0] src [4];
  assign elem_rd_data = src[elem_rd_idx[1:0]];

  // Observation logs
  int          resp_delay = 0;
  int          wcnt = 0;
  bit          in_tx = 0;
  int          ntx_l, nwr_l, stab_err, stray_err, done_cyc;
  bit          done_seen, done_err;
  logic [31:0] l_addr [8];
  logic [31:0] l_wdata [8];
  logic [3:0]  l_wstrb [8];
  logic [7:0]  l_widx [8];
  logic [31:0] l_wdat [8];
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_valid) begin
        if (!in_tx) begin
          if (ntx_l < 8) begin
            l_addr[ntx_l]  = mem_addr;
            l_wdata[ntx_l] = mem_wdata;
            l_wstrb[ntx_l] = mem_wstrb;
          end
          ntx_l++;
          in_tx = 1;
        end else if (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_wstrb !== h_wstrb) begin
          stab_err++;
        end
        h_addr  = mem_addr;
        h_wdata = mem_wdata;
        h_wstrb = mem_wstrb;
      end else begin
        in_tx = 0;
      end
      if (elem_wr_valid) begin
        if (nwr_l < 8) begin
          l_widx[nwr_l] = elem_wr_idx;
          l_wdat[nwr_l] = elem_wr_data;
        end
        nwr_l++;
      end
      if (done) begin
        done_seen = 1;
        done_err  = err;
        done_cyc  = cyc;
      end else if (err) begin
        stray_err++;
      end
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end else if (mem_valid) begin
        if (wcnt >= resp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_words[mem_addr[11:2]];
        end else begin
          wcnt++;
        end
      end
    end else begin
      in_tx     = 0;
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  typedef struct {
    logic             store;
    logic [1:0]       sew;
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [7:0]       vl;
    int               delay;
    logic             exp_err;
    int               exp_lat;
    int               ntx;
    int               nwr;
    logic [3:0][31:0] t_addr;
    logic [3:0][31:0] t_wdata;
    logic [3:0][3:0]  t_wstrb;
    logic [3:0][7:0]  w_idx;
    logic [3:0][31:0] w_data;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmd(input int k, input logic st, input logic [1:0] sew, input logic [31:0] base,
                     input logic [31:0] stride, input logic [7:0] vl, input int dly,
                     input logic e, input int lat);
    vecs[k].store   = st;
    vecs[k].sew     = sew;
    vecs[k].base    = base;
    vecs[k].stride  = stride;
    vecs[k].vl      = vl;
    vecs[k].delay   = dly;
    vecs[k].exp_err = e;
    vecs[k].exp_lat = lat;
    vecs[k].ntx     = 0;
    vecs[k].nwr     = 0;
    vecs[k].t_addr  = '0;
    vecs[k].t_wdata = '0;
    vecs[k].t_wstrb = '0;
    vecs[k].w_idx   = '0;
    vecs[k].w_data  = '0;
  endtask

  task automatic tx(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    vecs[k].t_addr[vecs[k].ntx]  = a;
    vecs[k].t_wdata[vecs[k].ntx] = d;
    vecs[k].t_wstrb[vecs[k].ntx] = s;
    vecs[k].ntx++;
  endtask

  task automatic wr(input int k, input logic [7:0] idx, input logic [31:0] d);
    vecs[k].w_idx[vecs[k].nwr]  = idx;
    vecs[k].w_data[vecs[k].nwr] = d;
    vecs[k].nwr++;
  endtask

  task automatic clear_logs();
    ntx_l = 0; nwr_l = 0; stab_err = 0; stray_err = 0;
    done_seen = 0; done_err = 0; done_cyc = 0;
  endtask

  task automatic run(input int k);
    int acc;
    clear_logs();
    resp_delay = vecs[k].delay;
    for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
    @(negedge clk);
    cmd_store  = vecs[k].store;
    cmd_sew    = vecs[k].sew;
    cmd_base   = vecs[k].base;
    cmd_stride = vecs[k].stride;
    cmd_vl     = vecs[k].vl;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    for (int t = 0; t < 200 && !done_seen; t++) begin
      @(negedge clk);
      #1;
    end
    chk($sformatf("v%0d done_seen", k), {31'b0, done_seen}, 32'd1);
    chk($sformatf("v%0d ntx", k), ntx_l, vecs[k].ntx);
    for (int n = 0; n < vecs[k].ntx && n < ntx_l; n++) begin
      chk($sformatf("v%0d addr%0d", k, n), l_addr[n], vecs[k].t_addr[n]);
      chk($sformatf("v%0d wdata%0d", k, n), l_wdata[n], vecs[k].t_wdata[n]);
      chk($sformatf("v%0d wstrb%0d", k, n), {28'b0, l_wstrb[n]}, {28'b0, vecs[k].t_wstrb[n]});
    end
    chk($sformatf("v%0d nwr", k), nwr_l, vecs[k].nwr);
    for (int n = 0; n < vecs[k].nwr && n < nwr_l; n++) begin
      chk($sformatf("v%0d wr_idx%0d", k, n), {24'b0, l_widx[n]}, {24'b0, vecs[k].w_idx[n]});
      chk($sformatf("v%0d wr_data%0d", k, n), l_wdat[n], vecs[k].w_data[n]);
    end
    chk($sformatf("v%0d err", k), {31'b0, done_err}, {31'b0, vecs[k].exp_err});
    chk($sformatf("v%0d stable", k), stab_err, 0);
    chk($sformatf("v%0d stray_err", k), stray_err, 0);
    if (vecs[k].exp_lat >= 0)
      chk($sformatf("v%0d latency", k), done_cyc - acc, vecs[k].exp_lat);
  endtask

  initial begin
    resetn     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_store  = 1'b0;
    cmd_base   = '0;
    cmd_stride = '0;
    cmd_vl     = '0;
    cmd_sew    = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    clear_logs();
    for (int w = 0; w < 1024; w++) mem_words[w] = 32'h0;
    mem_words[100]  = 32'h0101_0101;
    mem_words[125]  = 32'h4433_2211;
    mem_words[126]  = 32'hDEAD_BEEF;
    mem_words[250]  = 32'h1234_5678;
    mem_words[251]  = 32'h9ABC_DEF0;
    mem_words[1023] = 32'hA500_0000;
    mem_words[0]    = 32'h0000_0077;
    src[0] = 32'hAABB_CC5A;
    src[1] = 32'h1122_333C;
    src[2] = 32'h5555_5555;
    src[3] = 32'h6666_6666;

    //   k  st    sew    base          stride        vl  dly err lat
    cmd(0,  1'b0, 2'b00, 32'd400,      32'd1,        4,  0,  0,  10);
    tx(0, 32'd400, 32'h0, 4'b0000); tx(0, 32'd401, 32'h0, 4'b0000);
    tx(0, 32'd402, 32'h0, 4'b0000); tx(0, 32'd403, 32'h0, 4'b0000);
    wr(0, 0, 32'h01); wr(0, 1, 32'h01); wr(0, 2, 32'h01); wr(0, 3, 32'h01);
    cmd(1,  1'b0, 2'b00, 32'd500,      32'd1,        4,  3,  0,  -1);
    tx(1, 32'd500, 32'h0, 4'b0000); tx(1, 32'd501, 32'h0, 4'b0000);
    tx(1, 32'd502, 32'h0, 4'b0000); tx(1, 32'd503, 32'h0, 4'b0000);
    wr(1, 0, 32'h11); wr(1, 1, 32'h22); wr(1, 2, 32'h33); wr(1, 3, 32'h44);
    cmd(2,  1'b0, 2'b01, 32'd502,      32'hFFFF_FFFE, 2, 1,  0,  -1);
    tx(2, 32'd502, 32'h0, 4'b0000); tx(2, 32'd500, 32'h0, 4'b0000);
    wr(2, 0, 32'h4433); wr(2, 1, 32'h2211);
    cmd(3,  1'b0, 2'b10, 32'd500,      32'd4,        2,  0,  0,  -1);
    tx(3, 32'd500, 32'h0, 4'b0000); tx(3, 32'd504, 32'h0, 4'b0000);
    wr(3, 0, 32'h4433_2211); wr(3, 1, 32'hDEAD_BEEF);
    cmd(4,  1'b1, 2'b00, 32'd800,      32'd1,        2,  0,  0,  -1);
    tx(4, 32'd800, 32'h0000_005A, 4'b0001); tx(4, 32'd801, 32'h0000_3C00, 4'b0010);
    cmd(5,  1'b1, 2'b01, 32'd802,      32'hFFFF_FFFE, 2, 0,  0,  -1);
    tx(5, 32'd802, 32'hCC5A_0000, 4'b1100); tx(5, 32'd800, 32'h0000_333C, 4'b0011);
    cmd(6,  1'b1, 2'b10, 32'd900,      32'd8,        2,  3,  0,  -1);
    tx(6, 32'd900, 32'hAABB_CC5A, 4'b1111); tx(6, 32'd908, 32'h1122_333C, 4'b1111);
    cmd(7,  1'b0, 2'b01, 32'd401,      32'd2,        3,  0,  1,  5);
    cmd(8,  1'b0, 2'b10, 32'd1000,     32'd2,        3,  0,  1,  7);
    tx(8, 32'd1000, 32'h0, 4'b0000); tx(8, 32'd1004, 32'h0, 4'b0000);
    wr(8, 0, 32'h1234_5678); wr(8, 2, 32'h9ABC_DEF0);
    cmd(9,  1'b0, 2'b00, 32'd400,      32'd1,        0,  0,  0,  2);
    cmd(10, 1'b1, 2'b11, 32'd800,      32'd4,        3,  0,  1,  2);
    cmd(11, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1,       2,  0,  0,  -1);
    tx(11, 32'hFFFF_FFFF, 32'h0, 4'b0000); tx(11, 32'h0000_0000, 32'h0, 4'b0000);
    wr(11, 0, 32'hA5); wr(11, 1, 32'h77);

    #1 resetn = 1'b0;
    #3;
    chk("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst elem_wr_valid", {31'b0, elem_wr_valid}, 32'd0);
    chk("rst done_err", {30'b0, done, err}, 32'd0);
    chk("rst rd_idx", {24'b0, elem_rd_idx}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst cmd_ready", {31'b0, cmd_ready}, 32'd1);

    for (int k = 0; k < NV; k++) run(k);

    // Reset while element 1 of a load is waiting on a slow responder
    clear_logs();
    resp_delay = 6;
    @(negedge clk);
    cmd_store  = 1'b0;
    cmd_sew    = 2'b00;
    cmd_base   = 32'd400;
    cmd_stride = 32'd1;
    cmd_vl     = 8'd4;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int t = 0; t < 100 && ntx_l < 2; t++) begin
      @(negedge clk);
      #1;
    end
    chk("rstwait reached elem1", ntx_l, 2);
    #2 resetn = 1'b0;
    #1;
    chk("rstwait mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rstwait mem_addr", mem_addr, 32'd0);
    chk("rstwait rd_idx", {24'b0, elem_rd_idx}, 32'd0);
    chk("rstwait cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rstwait wr_valid", {31'b0, elem_wr_valid}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("rstwait no late wr", nwr_l, 1);
    chk("rstwait no done", {31'b0, done_seen}, 32'd0);
    run(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
